// File: rtl/sec_bloques_datos.sv
// Enable sequencer for the clock/date/chronometer counter blocks: one-hot enables,
// manual single-channel dwell or full scan with a one-cycle gap between channels.
module sec_bloques_datos #(
   parameter int N_CH    = 5,
   parameter int SEL_W   = 4,
   parameter int DWELL_W = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_modo,
   input  logic [SEL_W-1:0]   i_selec,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [N_CH-1:0]    o_enable_cont,
   output logic [SEL_W-1:0]   o_canal_act,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error_sel
);

   typedef enum logic [1:0] {IDLE, HOLD, GAP, FIN} state_t;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   state_t             r_state;
   state_t             w_next;
   logic               r_modo;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;
   logic [SEL_W-1:0]   r_canal;
   logic [SEL_W-1:0]   w_canal_next;
   logic [N_CH-1:0]    w_enable_next;
   logic               w_busy_next;
   logic               w_done_next;
   logic               w_err_next;
   logic               w_sel_bad;
   logic               w_last;

   // One extra bit so that N_CH = 2^SEL_W never flags a selection as invalid.
   assign w_sel_bad = ({1'b0, i_selec} >= (SEL_W + 1)'(N_CH));
   assign w_last    = (r_cnt == r_dwell);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (i_start && (i_modo || !w_sel_bad)) w_next = HOLD;
         HOLD: if (w_last) w_next = (!r_modo || r_canal == LAST_CH) ? FIN : GAP;
         GAP:  w_next = HOLD;
         FIN:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead from the next state and then registered.
   always_comb begin
      w_canal_next = r_canal;
      if (r_state == IDLE && w_next == HOLD) w_canal_next = i_modo ? '0 : i_selec;
      else if (r_state == GAP)               w_canal_next = r_canal + 1'b1;
      w_enable_next = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (w_next == HOLD && w_canal_next == SEL_W'(k)) w_enable_next[k] = 1'b1;
      end
      w_busy_next = (w_next == HOLD) || (w_next == GAP);
      w_done_next = (w_next == FIN);
      w_err_next  = (r_state == IDLE) && i_start && !i_modo && w_sel_bad;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_modo        <= 1'b0;
         r_dwell       <= DWELL_W'(1);
         r_cnt         <= '0;
         r_canal       <= '0;
         o_enable_cont <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_error_sel   <= 1'b0;
      end else begin
         if (r_state == IDLE && i_start) begin
            r_modo  <= i_modo;
            r_dwell <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
         end
         if (w_next == HOLD && r_state != HOLD) r_cnt <= DWELL_W'(1);
         else if (r_state == HOLD && !w_last)   r_cnt <= r_cnt + 1'b1;
         r_canal       <= w_canal_next;
         o_enable_cont <= w_enable_next;
         o_busy        <= w_busy_next;
         o_done        <= w_done_next;
         o_error_sel   <= w_err_next;
      end
   end

   assign o_canal_act = r_canal;

endmodule
